// File: rtl/sd_image_sched_if.sv
// Bundle of request, FIFO-level, SD command and status signals between the
// capture logic, the SD controller and the image scheduler.
interface sd_image_sched_if #(
    parameter int unsigned LEN_W = 10
);
    logic             sd_init_done;
    logic             save_req;
    logic             read_req;
    logic [LEN_W-1:0] wr_fifo_len;
    logic             wr_busy;
    logic             rd_busy;
    logic             wr_start_en;
    logic [31:0]      wr_sec_addr;
    logic             rd_start_en;
    logic [31:0]      rd_sec_addr;
    logic             wdata_sel;
    logic             wr_image_done;
    logic             rd_image_done;
    logic [2:0]       sched_state;

    modport master (
        input  sd_init_done, save_req, read_req, wr_fifo_len, wr_busy, rd_busy,
        output wr_start_en, wr_sec_addr, rd_start_en, rd_sec_addr, wdata_sel,
        output wr_image_done, rd_image_done, sched_state
    );

    modport slave (
        output sd_init_done, save_req, read_req, wr_fifo_len, wr_busy, rd_busy,
        input  wr_start_en, wr_sec_addr, rd_start_en, rd_sec_addr, wdata_sel,
        input  wr_image_done, rd_image_done, sched_state
    );
endinterface

// File: rtl/sd_image_sched.sv
// Whole-image SD transfer sequencer: one single-sector command per step, saves
// take priority over reads, sector address advances per completed sector.
module sd_image_sched #(
    parameter int unsigned SECTORS_PER_IMAGE = 1200,
    parameter logic [31:0] WR_BASE_ADDR      = 32'd16000,
    parameter logic [31:0] RD_BASE_ADDR      = 32'd16000,
    parameter int unsigned SECTOR_WORDS      = 256,
    parameter int unsigned LEN_W             = 10
) (
    input logic              SD_clk_ref,
    input logic              sys_rst_n,
    sd_image_sched_if.master bus
);
    localparam int unsigned CNT_W =
        (SECTORS_PER_IMAGE > 1) ? $clog2(SECTORS_PER_IMAGE) : 1;
    localparam logic [CNT_W-1:0] LAST_SEC = CNT_W'(SECTORS_PER_IMAGE - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWrWait = 3'd1,
        StWrCmd  = 3'd2,
        StWrAck  = 3'd3,
        StWrRun  = 3'd4,
        StRdCmd  = 3'd5,
        StRdAck  = 3'd6,
        StRdRun  = 3'd7
    } state_e;

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_wr_cnt, w_wr_cnt_nxt;
    logic [CNT_W-1:0] r_rd_cnt, w_rd_cnt_nxt;
    logic             r_save_pend, w_save_pend_nxt;
    logic             r_read_pend, w_read_pend_nxt;
    logic             r_wr_busy, r_rd_busy;
    logic             r_wr_start, w_wr_start_nxt;
    logic             r_rd_start, w_rd_start_nxt;
    logic [31:0]      r_wr_addr, w_wr_addr_nxt;
    logic [31:0]      r_rd_addr, w_rd_addr_nxt;
    logic             r_wdata_sel, w_wdata_sel_nxt;
    logic             r_wr_done, w_wr_done_nxt;
    logic             r_rd_done, w_rd_done_nxt;

    logic             w_wr_fall, w_rd_fall;
    logic             w_wr_active, w_rd_active;
    logic             w_fifo_ready;
    logic [LEN_W-1:0] w_fifo_len;

    assign w_fifo_len   = bus.wr_fifo_len;
    assign w_fifo_ready = (32'(w_fifo_len) >= SECTOR_WORDS);
    assign w_wr_fall    = r_wr_busy & ~bus.wr_busy;
    assign w_rd_fall    = r_rd_busy & ~bus.rd_busy;
    assign w_wr_active  = r_state inside {StWrWait, StWrCmd, StWrAck, StWrRun};
    assign w_rd_active  = r_state inside {StRdCmd, StRdAck, StRdRun};

    always_comb begin
        w_state_nxt     = r_state;
        w_wr_cnt_nxt    = r_wr_cnt;
        w_rd_cnt_nxt    = r_rd_cnt;
        w_save_pend_nxt = r_save_pend;
        w_read_pend_nxt = r_read_pend;
        w_wr_start_nxt  = 1'b0;
        w_rd_start_nxt  = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_rd_addr_nxt   = r_rd_addr;
        w_wdata_sel_nxt = r_wdata_sel;
        w_wr_done_nxt   = 1'b0;
        w_rd_done_nxt   = 1'b0;

        // A request for an image already in flight is dropped.
        if (bus.save_req && !w_wr_active) w_save_pend_nxt = 1'b1;
        if (bus.read_req && !w_rd_active) w_read_pend_nxt = 1'b1;

        if (r_state != StIdle && !bus.sd_init_done) begin
            w_state_nxt     = StIdle;
            w_wdata_sel_nxt = 1'b0;
            if (w_wr_active) w_wr_cnt_nxt = '0;
            else             w_rd_cnt_nxt = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.sd_init_done) begin
                        if (r_save_pend) begin
                            w_state_nxt     = StWrWait;
                            w_save_pend_nxt = 1'b0;
                            w_wdata_sel_nxt = 1'b1;
                        end else if (r_read_pend) begin
                            w_state_nxt     = StRdCmd;
                            w_read_pend_nxt = 1'b0;
                        end
                    end
                end
                StWrWait: begin
                    w_wdata_sel_nxt = 1'b1;
                    if (w_fifo_ready && !bus.wr_busy) w_state_nxt = StWrCmd;
                end
                StWrCmd: begin
                    w_wr_start_nxt = 1'b1;
                    w_wr_addr_nxt  = WR_BASE_ADDR + 32'(r_wr_cnt);
                    w_state_nxt    = StWrAck;
                end
                StWrAck: if (bus.wr_busy) w_state_nxt = StWrRun;
                StWrRun: begin
                    if (w_wr_fall) begin
                        if (r_wr_cnt == LAST_SEC) begin
                            w_wr_cnt_nxt    = '0;
                            w_wr_done_nxt   = 1'b1;
                            w_wdata_sel_nxt = 1'b0;
                            w_state_nxt     = StIdle;
                        end else begin
                            w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
                            w_state_nxt  = StWrWait;
                        end
                    end
                end
                StRdCmd: begin
                    w_rd_start_nxt = 1'b1;
                    w_rd_addr_nxt  = RD_BASE_ADDR + 32'(r_rd_cnt);
                    w_state_nxt    = StRdAck;
                end
                StRdAck: if (bus.rd_busy) w_state_nxt = StRdRun;
                StRdRun: begin
                    if (w_rd_fall) begin
                        if (r_rd_cnt == LAST_SEC) begin
                            w_rd_cnt_nxt  = '0;
                            w_rd_done_nxt = 1'b1;
                            w_state_nxt   = StIdle;
                        end else begin
                            w_rd_cnt_nxt = r_rd_cnt + CNT_W'(1);
                            w_state_nxt  = StRdCmd;
                        end
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge SD_clk_ref or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= StIdle;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_save_pend <= 1'b0;
            r_read_pend <= 1'b0;
            r_wr_busy   <= 1'b0;
            r_rd_busy   <= 1'b0;
            r_wr_start  <= 1'b0;
            r_rd_start  <= 1'b0;
            r_wr_addr   <= WR_BASE_ADDR;
            r_rd_addr   <= RD_BASE_ADDR;
            r_wdata_sel <= 1'b0;
            r_wr_done   <= 1'b0;
            r_rd_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_save_pend <= w_save_pend_nxt;
            r_read_pend <= w_read_pend_nxt;
            r_wr_busy   <= bus.wr_busy;
            r_rd_busy   <= bus.rd_busy;
            r_wr_start  <= w_wr_start_nxt;
            r_rd_start  <= w_rd_start_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_wdata_sel <= w_wdata_sel_nxt;
            r_wr_done   <= w_wr_done_nxt;
            r_rd_done   <= w_rd_done_nxt;
        end
    end

    assign bus.wr_start_en   = r_wr_start;
    assign bus.wr_sec_addr   = r_wr_addr;
    assign bus.rd_start_en   = r_rd_start;
    assign bus.rd_sec_addr   = r_rd_addr;
    assign bus.wdata_sel     = r_wdata_sel;
    assign bus.wr_image_done = r_wr_done;
    assign bus.rd_image_done = r_rd_done;
    assign bus.sched_state   = r_state;
endmodule

// File: doc/sd_image_sched.md
Name: sd_image_sched

Overview:
- Sequences whole-image transfers between the image FIFOs and the SD sector controller: issues one single-sector write or read command per transaction and advances the sector address.
- Arbitrates pending camera save requests against image read requests.
- Sits between the capture/record logic and the SD controller's user write and read ports.
- Clocked on SD_clk_ref, the same domain as the SD controller user interface and the FIFO SD-side ports.

Parameters:
- SECTORS_PER_IMAGE, 1200: sectors per image (640x480x16 bit / 512 bytes).
- WR_BASE_ADDR, 32'd16000: first sector of the saved image.
- RD_BASE_ADDR, 32'd16000: first sector of the image that is read back.
- SECTOR_WORDS, 256: 16-bit words per sector; also the FIFO level needed before a write may start.
- LEN_W, 10: width of the write-FIFO level input.

Ports:
- SD_clk_ref  in  1  clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- sd_init_done  in  1  SD card initialised (level).
- save_req  in  1  one-cycle pulse: save one image.
- read_req  in  1  one-cycle pulse: read one image.
- wr_fifo_len  in  LEN_W  write-FIFO fill level in 16-bit words.
- wr_busy  in  1  SD controller write busy.
- rd_busy  in  1  SD controller read busy.
- wr_start_en  out  1  one-cycle write command.
- wr_sec_addr  out  32  write sector address.
- rd_start_en  out  1  one-cycle read command.
- rd_sec_addr  out  32  read sector address.
- wdata_sel  out  1  1 = SD write data is taken from the FIFO.
- wr_image_done  out  1  one-cycle pulse: last sector of the image written.
- rd_image_done  out  1  one-cycle pulse: last sector of the image read.
- sched_state  out  3  current state encoding, for debug.

Behaviour:
- Reset values:
  - all outputs 0, except wr_sec_addr = WR_BASE_ADDR and rd_sec_addr = RD_BASE_ADDR.
  - state IDLE, sector counters 0, pending flags 0.
- Request latching:
  - save_req sets save_pend; read_req sets read_pend, in any state.
  - A pend flag clears on the cycle its image transfer starts (counter = 0 leaving IDLE).
  - A repeated request while its pend flag is set or its image is in progress is dropped.
- Busy edges: wr_busy and rd_busy are each registered once; a falling edge means prev=1 and cur=0.
- States and encoding:
  - IDLE=0
  - WR_WAIT=1
  - WR_CMD=2
  - WR_ACK=3
  - WR_RUN=4
  - RD_CMD=5
  - RD_ACK=6
  - RD_RUN=7
- IDLE:
  - No action unless sd_init_done=1. Requests that arrive earlier stay pending.
  - Write has priority: if save_pend is set, go to WR_WAIT; otherwise if read_pend is set, go to RD_CMD.
- WR_WAIT:
  - Hold wdata_sel=1.
  - When wr_fifo_len >= SECTOR_WORDS and wr_busy=0, go to WR_CMD.
- WR_CMD:
  - wr_start_en=1 for exactly one cycle.
  - wr_sec_addr = WR_BASE_ADDR + wr_cnt, held stable from this cycle until WR_RUN exits.
  - Next state WR_ACK.
- WR_ACK: wait for wr_busy=1, then go to WR_RUN.
- WR_RUN:
  - On the wr_busy falling edge, compare wr_cnt with SECTORS_PER_IMAGE-1.
  - Not last: wr_cnt+1 and return to WR_WAIT. The image always completes before any read is serviced.
  - Last: wr_cnt wraps to 0, wr_image_done pulses for 1 cycle, wdata_sel clears, return to IDLE.
- Read path (RD_CMD / RD_ACK / RD_RUN):
  - Same handshake as the write path, using rd_cnt, rd_start_en, rd_busy and rd_image_done.
  - No FIFO-level gating; wdata_sel stays 0.
- Priority between images: after an image completes, IDLE re-arbitrates. A read that is pending during a write runs immediately after that write's wr_image_done.
- Latency:
  - The start pulse comes 1 cycle after entering WR_CMD or RD_CMD.
  - The next command comes no sooner than 2 cycles after the busy falling edge.
- Address arithmetic: unsigned 32-bit addition; counters are ceil(log2(SECTORS_PER_IMAGE)) bits wide.
- Loss of initialisation: if sd_init_done drops outside IDLE, return to IDLE, clear the counter of the active image and clear wdata_sel. Pending flags are kept.
- Reset mid-transfer: everything returns to its reset values asynchronously; no done pulse is produced.

Test Plan:
1. Bench with SECTORS_PER_IMAGE=4 and a simple busy model (busy high 1 cycle after start, for 20 cycles). Pulse save_req with wr_fifo_len=300 -> four wr_start_en pulses at addresses 16000..16003, then one wr_image_done, wdata_sel back to 0.
2. wr_fifo_len=100 after a save_req -> no wr_start_en. Raise wr_fifo_len to 256 -> wr_start_en within 2 cycles.
3. save_req and read_req in the same cycle -> all 4 writes complete, then rd_start_en at 16000..16003, rd_image_done last. No overlap between wr_busy and rd_start_en.
4. read_req pulsed while sd_init_done=0 -> no command. Raise sd_init_done -> read starts at 16000.
5. Drop sd_init_done during the 3rd write -> IDLE, wdata_sel=0. Re-assert it with save_pend re-requested -> the next write uses address 16000.
6. Assert sys_rst_n=0 mid-read -> outputs at reset values in the same cycle, rd_sec_addr=16000, and no rd_image_done.
